// File: rtl/jk_excitation_driver.sv
// Drives J/K for a bank of JK flops from a queue of desired next-state vectors,
// then checks the flop outputs one cycle after the drive edge.
module jk_excitation_driver #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DC_MODE    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic [WIDTH-1:0] q_in,
  input  logic             err_clr,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  output logic [15:0]      done_cnt,
  output logic             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic [15:0]      done_cnt_q, done_cnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             chk;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] j_exc;
  logic [WIDTH-1:0] k_exc;
  logic [WIDTH-1:0] mismatch;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = tgt_valid & ~fifo_full;
  assign head       = fifo_mem_q[rd_ptr_q];
  assign mismatch   = q_in ^ tgt_q;

  // Excitation from present Q; DC_MODE only decides how the don't-care input is filled.
  always_comb begin
    j_exc = ~q_in & head;
    k_exc = q_in & ~head;
    if (DC_MODE != 0) begin
      j_exc = q_in | head;
      k_exc = ~q_in | ~head;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= tgt_data;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    pop     = 1'b0;
    chk     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          tgt_d   = head;
          j_d     = j_exc;
          k_d     = k_exc;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        chk = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          tgt_d   = head;
          j_d     = j_exc;
          k_d     = k_exc;
          state_d = S_DRIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A clear coinciding with a check keeps only that check's mismatch bits.
  always_comb begin
    err_d      = err_q;
    err_mask_d = err_mask_q;
    done_cnt_d = done_cnt_q;
    if (err_clr) begin
      err_d      = chk & (|mismatch);
      err_mask_d = chk ? mismatch : '0;
    end else if (chk) begin
      err_d      = err_q | (|mismatch);
      err_mask_d = err_mask_q | mismatch;
    end
    if (chk && (done_cnt_q != 16'hFFFF)) begin
      done_cnt_d = done_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tgt_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tgt_q      <= tgt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign tgt_ready = ~fifo_full;
  assign j_out     = j_q;
  assign k_out     = k_q;
  assign err       = err_q;
  assign err_mask  = err_mask_q;
  assign done_cnt  = done_cnt_q;
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two drivers (DC_MODE 0 and 1) share stimulus, each with its own JK flop model.
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tgt_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] tgt_data = 4'h0;
  logic [3:0] stuck = 4'h0;
  logic [3:0] raw0 = 4'h0;
  logic [3:0] raw1 = 4'h0;
  logic [3:0] q0, q1;

  logic        ready0, ready1, err0, err1, busy0, busy1;
  logic [3:0]  j0, k0, j1, k1, mask0, mask1;
  logic [15:0] done0, done1;

  int checks = 0;
  int failures = 0;
  int idx, stalls, acc_before_stall;
  logic [3:0] cj0, ck0, cj1, ck1;
  logic [3:0] v3 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                         4'b1111, 4'b0000, 4'b1100, 4'b0011};
  logic [3:0] v5 [6] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000};

  assign q0 = raw0 & ~stuck;
  assign q1 = raw1 & ~stuck;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    raw0 <= (j0 & ~raw0) | (~k0 & raw0);
    raw1 <= (j1 & ~raw1) | (~k1 & raw1);
  end

  jk_excitation_driver #(.WIDTH(4), .FIFO_DEPTH(4), .DC_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(ready0),
    .tgt_data(tgt_data), .j_out(j0), .k_out(k0), .q_in(q0), .err_clr(err_clr),
    .err(err0), .err_mask(mask0), .done_cnt(done0), .busy(busy0));

  jk_excitation_driver #(.WIDTH(4), .FIFO_DEPTH(4), .DC_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(ready1),
    .tgt_data(tgt_data), .j_out(j1), .k_out(k1), .q_in(q1), .err_clr(err_clr),
    .err(err1), .err_mask(mask1), .done_cnt(done1), .busy(busy1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One target from IDLE/empty; returns at the negedge after its check edge.
  task automatic run_one(input logic [3:0] t, input logic clr_in_check);
    tgt_data  = t;
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    @(negedge clk);
    cj0 = j0; ck0 = k0; cj1 = j1; ck1 = k1;
    @(negedge clk);
    err_clr = clr_in_check;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert ((j0 & k0) === 4'b0000) else begin
        failures++;
        $error("FAIL dc0_jk_both observed=%b expected=0000", j0 & k0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_j", j0, 4'h0);
    check("rst_k", k0, 4'h0);
    check("rst_err", err0, 1'b0);
    check("rst_mask", mask0, 4'h0);
    check("rst_done", done0, 16'h0);
    check("rst_ready", ready0, 1'b1);
    check("rst_busy", busy0, 1'b0);

    // 1: Q=0000 -> 1010
    run_one(4'b1010, 1'b0);
    check("t1_j0", cj0, 4'b1010);
    check("t1_k0", ck0, 4'b0000);
    check("t1_j1", cj1, 4'b1010);
    check("t1_k1", ck1, 4'b1111);
    check("t1_q0", q0, 4'b1010);
    check("t1_q1", q1, 4'b1010);
    check("t1_err", err0, 1'b0);
    check("t1_done", done0, 16'd1);
    check("t1_busy", busy0, 1'b0);

    // 2: Q=1010 -> 0110
    run_one(4'b0110, 1'b0);
    check("t2_j0", cj0, 4'b0100);
    check("t2_k0", ck0, 4'b1000);
    check("t2_j1", cj1, 4'b1110);
    check("t2_k1", ck1, 4'b1101);
    check("t2_q0", q0, 4'b0110);
    check("t2_q1", q1, 4'b0110);
    check("t2_done", done0, 16'd2);

    // 3: offer 8 vectors every cycle; FIFO fills after the 7th accept
    idx = 0; stalls = 0; acc_before_stall = -1;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      tgt_data  = v3[idx];
      tgt_valid = 1'b1;
      if (ready0) begin
        @(negedge clk);
        idx++;
      end else begin
        if (acc_before_stall < 0) acc_before_stall = idx;
        stalls++;
        @(negedge clk);
      end
    end
    tgt_valid = 1'b0;
    check("t3_all_pushed", idx, 8);
    check("t3_stalls", stalls, 1);
    check("t3_full_after", acc_before_stall, 7);
    repeat (20) @(negedge clk);
    check("t3_busy", busy0, 1'b0);
    check("t3_done0", done0, 16'd10);
    check("t3_done1", done1, 16'd10);
    check("t3_err", err0, 1'b0);
    check("t3_q0", q0, 4'b0011);
    check("t3_q1", q1, 4'b0011);

    // 4: bits 2 and 0 stuck at 0
    stuck = 4'b0101;
    run_one(4'b0101, 1'b0);
    check("t4_err0", err0, 1'b1);
    check("t4_mask0", mask0, 4'b0101);
    check("t4_err1", err1, 1'b1);
    check("t4_mask1", mask1, 4'b0101);
    run_one(4'b0100, 1'b1);
    check("t4_clr_err", err0, 1'b1);
    check("t4_clr_mask", mask0, 4'b0100);
    check("t4_clr_mask1", mask1, 4'b0100);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_clr_only_err", err0, 1'b0);
    check("t4_clr_only_mask", mask0, 4'b0000);
    stuck = 4'b0000;
    @(negedge clk);

    // 5: reset during DRIVE with three queued
    for (int i = 0; i < 6; i++) begin
      tgt_data  = v5[i];
      tgt_valid = 1'b1;
      @(negedge clk);
    end
    tgt_valid = 1'b0;
    check("t5_drive_j", j0, 4'b1111);
    check("t5_busy_pre", busy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_j0", j0, 4'h0);
    check("t5_async_k0", k0, 4'h0);
    check("t5_async_k1", k1, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_busy0", busy0, 1'b0);
    check("t5_busy1", busy1, 1'b0);
    check("t5_ready0", ready0, 1'b1);
    check("t5_ready1", ready1, 1'b1);
    check("t5_done", done0, 16'd0);
    repeat (4) @(negedge clk);
    check("t5_stay_idle", busy0, 1'b0);

    // 6: saturation of done_cnt
    force u_dut0.done_cnt_q = 16'hFFFD;
    #1;
    release u_dut0.done_cnt_q;
    #1;
    check("t6_preload", done0, 16'hFFFD);
    run_one(4'b1001, 1'b0);
    check("t6_fffe", done0, 16'hFFFE);
    run_one(4'b0110, 1'b0);
    check("t6_ffff", done0, 16'hFFFF);
    run_one(4'b1111, 1'b0);
    check("t6_sat", done0, 16'hFFFF);
    check("t6_err", err0, 1'b0);
    check("t6_done1", done1, 16'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
